conv_layer_seq: RTL

Sequencer for the convolution-layer accelerator. Accepts a start command with a word count and bias, soft-resets the accelerator, then streams 16-bit input words into it. It waits for the accelerator's finish, and hands the 32-bit result to a downstream valid/ready stream. Sits between the host/DMA input stream and the accelerator's input_port/bias/valid/reset/output_port/finish/invalid pins, and reports done/error status to the host.

---
 rtl/conv_layer_seq_if.sv | 52 +++++
 rtl/conv_layer_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_seq_if.sv
// ---------------------------------------------------------------------------
// conv_layer_seq_if
//   Stream and accelerator pins handled by the convolution-layer sequencer.
//
//   Groups:
//     in_*      host/DMA input stream (valid/ready, IN_W data)
//     acc_*     accelerator pins: input_port, bias, valid, reset (active-high),
//               output_port, finish, invalid
//     res_*     result stream to downstream (valid/ready, OUT_W data)
//
//   Modports:
//     master    the sequencer's view (drives in_ready, acc_* outputs, res_data/valid)
//     slave     the environment's view (source, accelerator, result sink)
// ---------------------------------------------------------------------------
interface conv_layer_seq_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;

    logic [IN_W-1:0]  acc_input_port;
    logic [31:0]      acc_bias;
    logic             acc_valid;
    logic             acc_reset;
    logic [OUT_W-1:0] acc_output_port;
    logic             acc_finish;
    logic             acc_invalid;

    logic [OUT_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output acc_input_port, acc_bias, acc_valid, acc_reset,
        input  acc_output_port, acc_finish, acc_invalid,
        output res_data, res_valid,
        input  res_ready
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  acc_input_port, acc_bias, acc_valid, acc_reset,
        output acc_output_port, acc_finish, acc_invalid,
        input  res_data, res_valid,
        output res_ready
    );
endinterface

// File: rtl/conv_layer_seq.sv
// ---------------------------------------------------------------------------
// conv_layer_seq
//   Job sequencer for the convolution-layer accelerator. A start command
//   latches a word count and bias, the accelerator is soft-reset for
//   ACC_RST_CYC cycles, cfg_len input words are forwarded to it, and the
//   result captured on finish is offered on the result stream. Each job ends
//   with a one-cycle done pulse carrying err/err_code.
//
//   Ports:
//     h_clk, reset        clock (posedge), asynchronous active-low reset
//     start               1-cycle job request, honoured only in IDLE
//     cfg_len, cfg_bias   job word count and bias, latched on accepted start
//     busy                high whenever the sequencer is not IDLE
//     done, err           1-cycle job-end pulse, err set on failure
//     err_code            00 ok, 01 accel invalid, 10 timeout, 11 zero length
//     bus                 conv_layer_seq_if.master: input stream,
//                         accelerator pins, result stream
//     perf_cycles         (CONV_SEQ_PERF_EN only) busy-cycle count of the
//                         last job, saturating
//
//   Optional feature macro: CONV_SEQ_PERF_EN
//   All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module conv_layer_seq #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT     = 4096,
    parameter int ACC_RST_CYC = 2
) (
    input  logic              h_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [31:0]       cfg_bias,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    conv_layer_seq_if.master  bus
);

    localparam int RC_W = (ACC_RST_CYC > 1) ? $clog2(ACC_RST_CYC) : 1;
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARST,
        S_FEED,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_INVALID  = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ZERO_LEN = 2'b11
    } err_t;

    state_t             state, state_nx;
    err_t               code_q, code_nx;
    logic [RC_W-1:0]    rcnt, rcnt_nx;
    logic [LEN_W-1:0]   wcnt, wcnt_nx;
    logic [TO_W-1:0]    tcnt, tcnt_nx;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        bias_q;

    logic               busy_q, done_q, err_q;
    logic               in_ready_q, acc_valid_q, acc_reset_q, res_valid_q;
    logic [IN_W-1:0]    acc_in_q;
    logic [OUT_W-1:0]   res_data_q;

    logic               start_acc;  // start accepted this cycle
    logic               hs;         // input-stream handshake this cycle
    logic               abort;      // accelerator reported invalid
    logic               capture;    // accelerator finished, take its result

    // in_ready is a flop that is only high in FEED, so the handshake needs no
    // separate state qualifier.
    assign hs = bus.in_valid & in_ready_q;

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        code_nx   = code_q;
        rcnt_nx   = rcnt;
        wcnt_nx   = wcnt;
        tcnt_nx   = tcnt;
        start_acc = 1'b0;
        abort     = 1'b0;
        capture   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    code_nx   = ERR_OK;
                    if (cfg_len == '0) begin
                        state_nx = S_DONE;
                        code_nx  = ERR_ZERO_LEN;
                    end else begin
                        state_nx = S_ARST;
                        rcnt_nx  = '0;
                    end
                end
            end

            S_ARST: begin
                if (rcnt == RC_W'(ACC_RST_CYC - 1)) begin
                    state_nx = S_FEED;
                    wcnt_nx  = '0;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
            end

            S_FEED: begin
                if (bus.acc_invalid) begin
                    abort    = 1'b1;
                    state_nx = S_DONE;
                    code_nx  = ERR_INVALID;
                end else if (hs) begin
                    wcnt_nx = wcnt + 1'b1;
                    // Checked before the register so in_ready falls on the
                    // same edge that takes the last word.
                    if (wcnt == len_q - LEN_W'(1)) begin
                        state_nx = S_WAIT;
                        tcnt_nx  = '0;
                    end
                end
            end

            S_WAIT: begin
                if (bus.acc_invalid) begin
                    abort    = 1'b1;
                    state_nx = S_DONE;
                    code_nx  = ERR_INVALID;
                end else if (bus.acc_finish) begin
                    capture  = 1'b1;
                    state_nx = S_OUT;
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    state_nx = S_DONE;
                    code_nx  = ERR_TIMEOUT;
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end

            S_OUT: begin
                if (res_valid_q && bus.res_ready) begin
                    state_nx = S_DONE;
                    code_nx  = ERR_OK;
                end
            end

            S_DONE: state_nx = S_IDLE;

            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state, so each one lines
    // up exactly with the state it describes.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge h_clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            code_q      <= ERR_OK;
            rcnt        <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            len_q       <= '0;
            bias_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_reset_q <= 1'b1;  // accelerator held in reset with us
            acc_in_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state       <= state_nx;
            code_q      <= code_nx;
            rcnt        <= rcnt_nx;
            wcnt        <= wcnt_nx;
            tcnt        <= tcnt_nx;
            busy_q      <= (state_nx != S_IDLE);
            done_q      <= (state_nx == S_DONE);
            err_q       <= (state_nx == S_DONE) && (code_nx != ERR_OK);
            in_ready_q  <= (state_nx == S_FEED);
            acc_valid_q <= hs;
            acc_reset_q <= (state_nx == S_ARST) || abort;
            res_valid_q <= (state_nx == S_OUT);
            if (hs) begin
                acc_in_q <= bus.in_data;
            end
            if (capture) begin
                res_data_q <= bus.acc_output_port;
            end
            if (start_acc) begin
                len_q  <= cfg_len;
                bias_q <= cfg_bias;
            end
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge h_clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign err_code           = code_q;
    assign bus.in_ready       = in_ready_q;
    assign bus.acc_input_port = acc_in_q;
    assign bus.acc_bias       = bias_q;
    assign bus.acc_valid      = acc_valid_q;
    assign bus.acc_reset      = acc_reset_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_valid      = res_valid_q;

endmodule
